tdc_uart_readout: RTL

TDC_UART_READOUT -- requirements
Module: tdc_uart_readout

---
 rtl/tdc_pkg.sv | 33 +++
 rtl/tdc_fifo.sv | 69 ++++++
 rtl/tdc_uart_readout.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// tdc_pkg: shared constants, FSM state encoding and frame byte selection
// for the TDC UART readout.
//   DIG_OUT          width of a TDC result word {coarse[9:0], start[6:0], stop[6:0]}
//   SYNC_BYTE        first byte of every frame, used by the receiver to align
//   BYTES_PER_FRAME  sync byte plus three payload bytes
//   tx_state_t       serializer FSM states
//   frame_byte()     byte of a frame by position (0 = sync, 1..3 = payload MSB first)
package tdc_pkg;

  localparam int         DIG_OUT         = 24;
  localparam logic [7:0] SYNC_BYTE       = 8'hA5;
  localparam int         BYTES_PER_FRAME = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  function automatic logic [7:0] frame_byte(input logic [23:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = SYNC_BYTE;
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tdc_fifo.sv
// tdc_fifo: synchronous FIFO buffering TDC result words ahead of the UART.
// Ports:
//   iClk, rst  clock and synchronous active-high reset
//   wr_en      write request; ignored while full
//   wr_data    word to write
//   rd_en      pop request; ignored while empty
//   rd_data    word at the head of the FIFO (valid while not empty)
//   full       count == DEPTH
//   empty      count == 0
//   count      words currently stored (registered)
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
module tdc_fifo #(
  parameter int WIDTH = tdc_pkg::DIG_OUT,
  parameter int DEPTH = 8
) (
  input  logic                     iClk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage has no reset; the pointers and count define what is valid.
  always_ff @(posedge iClk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge iClk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tdc_uart_readout.sv
// tdc_uart_readout: buffers TDC result words and streams each one over a
// UART (8N1, LSB first) as a 4-byte frame: A5, word[23:16], word[15:8], word[7:0].
// Ports:
//   iClk        system clock
//   rst         synchronous active-high reset; aborts any frame and empties the FIFO
//   iTdcData    TDC result word, sampled when iTdcValid=1
//   iTdcValid   single-cycle strobe for iTdcData
//   iClrOvf     clears oOverflow (a simultaneous drop keeps it set)
//   oTx         UART line, idle high
//   oBusy       high whenever the serializer FSM is not IDLE
//   oOverflow   sticky flag: a word was dropped because the FIFO was full
//   oFifoCount  words currently buffered
module tdc_uart_readout #(
  parameter int DIG_OUT      = tdc_pkg::DIG_OUT,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                          iClk,
  input  logic                          rst,
  input  logic [DIG_OUT-1:0]            iTdcData,
  input  logic                          iTdcValid,
  input  logic                          iClrOvf,
  output logic                          oTx,
  output logic                          oBusy,
  output logic                          oOverflow,
  output logic [$clog2(FIFO_DEPTH):0]   oFifoCount
);

  import tdc_pkg::*;

  localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [1:0]       LAST_BYTE = 2'(BYTES_PER_FRAME - 1);

  tx_state_t          state;
  tx_state_t          state_next;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic [DIG_OUT-1:0] fifo_rd_data;
  logic [DIG_OUT-1:0] frame_word;
  logic [CNT_W-1:0]   bit_cnt;
  logic               bit_tick;
  logic [2:0]         bit_idx;
  logic [1:0]         byte_idx;
  logic [7:0]         shift_reg;
  logic               tx;

  tdc_fifo #(
    .WIDTH (DIG_OUT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .iClk    (iClk),
    .rst     (rst),
    .wr_en   (iTdcValid),
    .wr_data (iTdcData),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (oFifoCount)
  );

  assign bit_tick = (bit_cnt == BIT_LAST);

  always_ff @(posedge iClk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (!fifo_empty) state_next = LOAD;
      LOAD:  state_next = START;
      START: if (bit_tick) state_next = DATA;
      DATA:  if (bit_tick && bit_idx == 3'd7) state_next = STOP;
      STOP:  if (bit_tick) state_next = (byte_idx == LAST_BYTE) ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  // oTx is a decode of registered state and shift register only, so the
  // start bit appears in the same cycle the FSM enters START.
  always_comb begin
    oBusy = 1'b1;
    tx    = 1'b1;
    pop   = 1'b0;
    case (state)
      IDLE: begin
        oBusy = 1'b0;
        pop   = !fifo_empty;
      end
      START:   tx = 1'b0;
      DATA:    tx = shift_reg[0];
      default: ;
    endcase
  end

  assign oTx = tx;

  // Serializer datapath: the popped word is held for the whole frame and
  // each byte is loaded into the shift register just before its start bit.
  always_ff @(posedge iClk) begin
    if (rst) begin
      frame_word <= '0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shift_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt  <= '0;
          bit_idx  <= '0;
          byte_idx <= '0;
          if (pop) begin
            frame_word <= fifo_rd_data;
          end
        end
        LOAD: begin
          bit_cnt   <= '0;
          byte_idx  <= '0;
          shift_reg <= frame_byte(frame_word[23:0], 2'd0);
        end
        START, DATA, STOP: begin
          bit_cnt <= bit_tick ? '0 : bit_cnt + 1'b1;
          if (state == DATA && bit_tick) begin
            shift_reg <= {1'b0, shift_reg[7:1]};
            bit_idx   <= bit_idx + 1'b1;
          end
          if (state == STOP && bit_tick && byte_idx != LAST_BYTE) begin
            byte_idx  <= byte_idx + 1'b1;
            shift_reg <= frame_byte(frame_word[23:0], byte_idx + 2'd1);
          end
        end
        default: ;
      endcase
    end
  end

  // A drop is judged against the full flag alone, so a pop in the same
  // cycle does not rescue the word; a drop also beats iClrOvf.
  always_ff @(posedge iClk) begin
    if (rst) begin
      oOverflow <= 1'b0;
    end else if (iTdcValid && fifo_full) begin
      oOverflow <= 1'b1;
    end else if (iClrOvf) begin
      oOverflow <= 1'b0;
    end
  end

endmodule
